// File: rtl/hdmi_fb_reader.sv
// 640x480 display timing generator and frame buffer reader with 2x upscale from 320x240.
// Returned RGB444 is aligned with the delayed sync/DE and expanded to RGB888.
module hdmi_fb_reader #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter bit          SYNC_ACTIVE = 1'b0,
   parameter int unsigned READ_LAT    = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_frame_ready,
   output logic        o_read_req,
   output logic [9:0]  o_read_x,
   output logic [8:0]  o_read_y,
   input  logic [11:0] i_read_data,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic [23:0] o_rgb,
   output logic        o_frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0]             r_h_cnt;
   logic [VW-1:0]             r_v_cnt;
   logic                      r_fr_meta;
   logic                      r_fr_sync;
   logic                      r_video_en;
   logic [READ_LAT-1:0][3:0]  r_pipe;
   logic                      r_de;
   logic                      r_hsync;
   logic                      r_vsync;
   logic [23:0]               r_rgb;

   logic       w_h_wrap;
   logic       w_v_wrap;
   logic       w_origin;
   logic       w_active;
   logic       w_hs;
   logic       w_vs;
   logic       w_video_en;
   logic       w_act_en;
   logic [3:0] w_pipe_in;
   logic [3:0] w_pipe_out;
   logic [3:0] w_r;
   logic [3:0] w_g;
   logic [3:0] w_b;

   always_comb begin
      w_h_wrap   = (r_h_cnt == H_LAST);
      w_v_wrap   = (r_v_cnt == V_LAST);
      w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
      w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
      w_hs       = (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
      w_vs       = (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);
      // Enable is taken at the origin and used in that same cycle, so frames are never torn.
      w_video_en = w_origin ? r_fr_sync : r_video_en;
      w_act_en   = w_active && w_video_en;
      // Pipe bit order: {act_en, vs, hs, active}
      w_pipe_in  = {w_act_en, w_vs, w_hs, w_active};
      w_pipe_out = r_pipe[READ_LAT-1];
      {w_r, w_g, w_b} = i_read_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_wrap) begin
         r_h_cnt <= '0;
         r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end else begin
         r_h_cnt <= r_h_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fr_meta  <= 1'b0;
         r_fr_sync  <= 1'b0;
         r_video_en <= 1'b0;
      end else begin
         r_fr_meta  <= i_frame_ready;
         r_fr_sync  <= r_fr_meta;
         r_video_en <= w_video_en;
      end
   end

   // Delay timing by the frame buffer read latency so it meets the returned data.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= w_pipe_in;
         for (int i = 1; i < READ_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_de    <= 1'b0;
         r_hsync <= ~SYNC_ACTIVE;
         r_vsync <= ~SYNC_ACTIVE;
         r_rgb   <= 24'h000000;
      end else begin
         r_de    <= w_pipe_out[0];
         r_hsync <= w_pipe_out[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_vsync <= w_pipe_out[2] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_rgb   <= w_pipe_out[3] ? {w_r, w_r, w_g, w_g, w_b, w_b} : 24'h000000;
      end
   end

   assign o_read_req    = w_act_en;
   assign o_read_x      = 10'(r_h_cnt >> 1);
   assign o_read_y      = 9'(r_v_cnt >> 1);
   assign o_frame_start = w_origin & ~i_rst;
   assign o_de          = r_de;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_rgb         = r_rgb;

endmodule

// File: tb/tb_hdmi_fb_reader.sv
// Bench for hdmi_fb_reader on a shrunken raster: randomized frame buffer contents checked
// against a cycle-count based reference model of timing, enable gating and pixel expansion.
module tb_hdmi_fb_reader;

   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 12, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int L  = 2;
   localparam bit SA = 1'b0;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [11:0] rdata;
   logic        o_read_req;
   logic [9:0]  o_read_x;
   logic [8:0]  o_read_y;
   logic        o_hsync;
   logic        o_vsync;
   logic        o_de;
   logic [23:0] o_rgb;
   logic        o_frame_start;

   hdmi_fb_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_ACTIVE(SA), .READ_LAT(L)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_frame_ready(rdy),
      .o_read_req(o_read_req),
      .o_read_x(o_read_x),
      .o_read_y(o_read_y),
      .i_read_data(rdata),
      .o_hsync(o_hsync),
      .o_vsync(o_vsync),
      .o_de(o_de),
      .o_rgb(o_rgb),
      .o_frame_start(o_frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {bit de; bit hsy; bit vsy; logic [23:0] rgb;} exp_t;
   typedef struct {bit req; int x; int y;} rd_t;

   exp_t        exp_q[$];
   rd_t         rd_q[$];
   logic [11:0] mem [0:HA/2-1][0:VA/2-1];

   int          n, h, v;
   bit          m_meta, m_sync, m_en;
   bit          e_req;
   int          e_x, e_y;
   logic [28:0] e_vec;
   logic [28:0] got;
   int          errors = 0;
   int          checks = 0;

   function automatic logic [23:0] expand(logic [11:0] p);
      return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
   endfunction

   task automatic model_init();
      exp_t e0;
      rd_t  r0;
      n = -1; h = 0; v = 0;
      m_meta = 0; m_sync = 0; m_en = 0;
      exp_q.delete();
      rd_q.delete();
      e0.de = 0; e0.hsy = ~SA; e0.vsy = ~SA; e0.rgb = 24'h0;
      r0.req = 0; r0.x = 0; r0.y = 0;
      for (int i = 0; i < L + 1; i++) exp_q.push_back(e0);
      for (int i = 0; i < L; i++) rd_q.push_back(r0);
   endtask

   // Advance one pixel clock: compute expectations for the current cycle and serve frame buffer.
   task automatic cyc();
      exp_t ent;
      rd_t  rq, rf;
      bit   act, hsa, vsa, fs;
      @(negedge clk);
      n++;
      h   = n % HT;
      v   = (n / HT) % VT;
      act = (h < HA) && (v < VA);
      hsa = (h >= HA + HF) && (h < HA + HF + HS);
      vsa = (v >= VA + VF) && (v < VA + VF + VS);
      fs  = (h == 0) && (v == 0);
      m_sync = m_meta;
      m_meta = (n == 0) ? 1'b0 : rdy;
      if (fs) m_en = m_sync;
      e_req   = act && m_en;
      e_x     = h / 2;
      e_y     = v / 2;
      ent.de  = act;
      ent.hsy = hsa ? SA : ~SA;
      ent.vsy = vsa ? SA : ~SA;
      ent.rgb = 24'h0;
      if (e_req) ent.rgb = expand(mem[h/2][v/2]);
      exp_q.push_back(ent);
      ent   = exp_q.pop_front();
      e_vec = {e_req, fs, ent.de, ent.hsy, ent.vsy, ent.rgb};
      rq.req = o_read_req;
      rq.x   = int'(o_read_x);
      rq.y   = int'(o_read_y);
      rd_q.push_back(rq);
      rf = rd_q.pop_front();
      if (rf.req && rf.x < HA / 2 && rf.y < VA / 2) rdata = mem[rf.x][rf.y];
      else rdata = 12'($urandom);
   endtask

   task automatic goto(int ht, int vt);
      int k = 0;
      do begin
         cyc();
         k++;
      end while (!(h == ht && v == vt) && k < 2 * FT);
      if (!(h == ht && v == vt)) begin
         errors++;
         $display("FAIL goto position got=(%0d,%0d) required=(%0d,%0d)", h, v, ht, vt);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_init();
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b0; rdata = 12'h0;
      for (int x = 0; x < HA / 2; x++)
         for (int y = 0; y < VA / 2; y++) mem[x][y] = 12'($urandom);
      #12;
      got = {o_read_req, o_frame_start, o_de, o_hsync, o_vsync, o_rgb};
      checks++;
      if (got !== {3'b000, ~SA, ~SA, 24'h0}) begin
         errors++;
         $display("FAIL reset_outputs got=%h required=%h", got, {3'b000, ~SA, ~SA, 24'h0});
      end
      checks++;
      if (o_read_x !== 10'd0 || o_read_y !== 9'd0) begin
         errors++;
         $display("FAIL reset_addr got=(%0d,%0d) required=(0,0)", o_read_x, o_read_y);
      end
      apply_reset();
   endtask

   task automatic test_idle_timing();
      int hs_lo = 0, vs_lo = 0, de_hi = 0, req_hi = 0;
      for (int i = 0; i < FT + L + 1; i++) begin
         cyc();
         got = {o_read_req, o_frame_start, o_de, o_hsync, o_vsync, o_rgb};
         checks++;
         if (got !== e_vec) begin
            errors++;
            $display("FAIL idle n=%0d got=%h required=%h", n, got, e_vec);
         end
         if (n >= L + 1) begin
            hs_lo  += (o_hsync === 1'b0) ? 1 : 0;
            vs_lo  += (o_vsync === 1'b0) ? 1 : 0;
            de_hi  += (o_de === 1'b1) ? 1 : 0;
         end
         req_hi += (o_read_req === 1'b1) ? 1 : 0;
      end
      checks++;
      if (hs_lo != HS * VT) begin
         errors++; $display("FAIL idle_hsync_low got=%0d required=%0d", hs_lo, HS * VT);
      end
      checks++;
      if (vs_lo != VS * HT) begin
         errors++; $display("FAIL idle_vsync_low got=%0d required=%0d", vs_lo, VS * HT);
      end
      checks++;
      if (de_hi != HA * VA) begin
         errors++; $display("FAIL idle_de_count got=%0d required=%0d", de_hi, HA * VA);
      end
      checks++;
      if (req_hi != 0) begin
         errors++; $display("FAIL idle_read_req got=%0d required=0", req_hi);
      end
   endtask

   task automatic test_enable_boundary();
      int k = 0, pre = 0;
      goto(0, VA / 2);
      rdy = 1'b1;
      do begin
         cyc();
         k++;
         if (!(h == 0 && v == 0)) pre += (o_read_req === 1'b1) ? 1 : 0;
      end while (!(h == 0 && v == 0) && k < 2 * FT);
      checks++;
      if (pre != 0) begin
         errors++; $display("FAIL enable_early_req got=%0d required=0", pre);
      end
      checks++;
      if ({o_read_req, o_frame_start} !== 2'b11 || o_read_x !== 10'd0 || o_read_y !== 9'd0) begin
         errors++;
         $display("FAIL enable_origin got req=%b fs=%b xy=(%0d,%0d) required 1 1 (0,0)",
                  o_read_req, o_frame_start, o_read_x, o_read_y);
      end
      for (int i = 1; i < 4; i++) begin
         cyc();
         checks++;
         if (o_read_req !== 1'b1 || o_read_x !== 10'(i / 2) || o_read_y !== 9'd0) begin
            errors++;
            $display("FAIL upscale_h%0d got req=%b xy=(%0d,%0d) required 1 (%0d,0)",
                     i, o_read_req, o_read_x, o_read_y, i / 2);
         end
      end
      goto(0, 2);
      checks++;
      if (o_read_req !== 1'b1 || o_read_x !== 10'd0 || o_read_y !== 9'd1) begin
         errors++;
         $display("FAIL upscale_v2 got req=%b xy=(%0d,%0d) required 1 (0,1)",
                  o_read_req, o_read_x, o_read_y);
      end
      goto(HA - 1, VA - 1);
      checks++;
      if (o_read_req !== 1'b1 || o_read_x !== 10'(HA / 2 - 1) || o_read_y !== 9'(VA / 2 - 1)) begin
         errors++;
         $display("FAIL upscale_last got req=%b xy=(%0d,%0d) required 1 (%0d,%0d)",
                  o_read_req, o_read_x, o_read_y, HA / 2 - 1, VA / 2 - 1);
      end
   endtask

   task automatic test_video_random();
      goto(0, VA);
      for (int x = 0; x < HA / 2; x++)
         for (int y = 0; y < VA / 2; y++) mem[x][y] = 12'($urandom);
      for (int i = 0; i < 2 * FT; i++) begin
         cyc();
         got = {o_read_req, o_frame_start, o_de, o_hsync, o_vsync, o_rgb};
         checks++;
         if (got !== e_vec) begin
            errors++;
            $display("FAIL video n=%0d got=%h required=%h", n, got, e_vec);
         end
         if (e_req) begin
            checks++;
            if (o_read_x !== 10'(e_x) || o_read_y !== 9'(e_y)) begin
               errors++;
               $display("FAIL video_addr n=%0d got=(%0d,%0d) required=(%0d,%0d)",
                        n, o_read_x, o_read_y, e_x, e_y);
            end
         end
      end
   endtask

   task automatic test_data_align();
      int req_at = -1, de_at = -1, k = 0;
      goto(0, VA);
      for (int x = 0; x < HA / 2; x++)
         for (int y = 0; y < VA / 2; y++) mem[x][y] = (x == 0) ? 12'hF80 : 12'h000;
      while (de_at < 0 && k < 2 * FT) begin
         cyc();
         k++;
         if (o_read_req === 1'b1 && req_at < 0) req_at = n;
         if (o_de === 1'b1 && req_at >= 0 && de_at < 0) de_at = n;
      end
      checks++;
      if (de_at < 0) begin
         errors++; $display("FAIL align_timeout got=no DE rise required=DE rise");
      end else begin
         checks++;
         if (de_at - req_at != L + 1) begin
            errors++;
            $display("FAIL align_latency got=%0d required=%0d", de_at - req_at, L + 1);
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_rgb !== ((i < 2) ? 24'hFF8800 : 24'h000000)) begin
               errors++;
               $display("FAIL align_rgb%0d got=%h required=%h", i, o_rgb,
                        (i < 2) ? 24'hFF8800 : 24'h000000);
            end
            cyc();
         end
      end
   endtask

   task automatic test_disable_midframe();
      int k = 0, r1 = 0, r2 = 0, nz = 0;
      goto(5, VA / 2);
      rdy = 1'b0;
      do begin
         cyc();
         k++;
         r1 += (o_read_req === 1'b1) ? 1 : 0;
         got = {o_read_req, o_frame_start, o_de, o_hsync, o_vsync, o_rgb};
         checks++;
         if (got !== e_vec) begin
            errors++; $display("FAIL disable n=%0d got=%h required=%h", n, got, e_vec);
         end
      end while (!(h == 0 && v == 0) && k < 2 * FT);
      for (int i = 0; i < FT; i++) begin
         cyc();
         r2 += (o_read_req === 1'b1) ? 1 : 0;
         nz += (o_rgb !== 24'h0) ? 1 : 0;
      end
      checks++;
      if (r1 != (HA - 6) + (VA - VA / 2 - 1) * HA) begin
         errors++;
         $display("FAIL disable_tail_reads got=%0d required=%0d", r1,
                  (HA - 6) + (VA - VA / 2 - 1) * HA);
      end
      checks++;
      if (r2 != 0 || nz != 0) begin
         errors++;
         $display("FAIL disable_next_frame got reads=%0d nonblack=%0d required 0 0", r2, nz);
      end
   endtask

   task automatic test_reset_midframe();
      int reqs = 0;
      rdy = 1'b1;
      goto(9, 7);
      #2 rst = 1'b1;
      #1;
      got = {o_read_req, o_frame_start, o_de, o_hsync, o_vsync, o_rgb};
      checks++;
      if (got !== {3'b000, ~SA, ~SA, 24'h0} || o_read_x !== 10'd0 || o_read_y !== 9'd0) begin
         errors++;
         $display("FAIL reset_async got=%h xy=(%0d,%0d) required=%h (0,0)",
                  got, o_read_x, o_read_y, {3'b000, ~SA, ~SA, 24'h0});
      end
      apply_reset();
      cyc();
      checks++;
      if (o_frame_start !== 1'b1) begin
         errors++; $display("FAIL reset_frame_start got=%b required=1", o_frame_start);
      end
      for (int i = 1; i < FT; i++) begin
         cyc();
         reqs += (o_read_req === 1'b1) ? 1 : 0;
         got = {o_read_req, o_frame_start, o_de, o_hsync, o_vsync, o_rgb};
         checks++;
         if (got !== e_vec) begin
            errors++; $display("FAIL post_reset n=%0d got=%h required=%h", n, got, e_vec);
         end
      end
      checks++;
      if (reqs != 0) begin
         errors++; $display("FAIL post_reset_reads got=%0d required=0", reqs);
      end
      cyc();
      checks++;
      if ({o_read_req, o_frame_start} !== 2'b11) begin
         errors++;
         $display("FAIL post_reset_enable got req=%b fs=%b required 1 1", o_read_req, o_frame_start);
      end
   endtask

   initial begin
      test_reset();
      test_idle_timing();
      test_enable_boundary();
      test_video_random();
      test_data_align();
      test_disable_midframe();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout required=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
